systolic_feeder: RTL and testbench

//  Upstream sequencer for the 2x2 systolic_array. Accepts a byte-serial load of
//  A (2x2) and B (2x2) operands, drives the skewed row/column streams into
//  in_a0/in_a1/in_b0/in_b1, and flushes the pipe with zeros. It then asserts

---
 rtl/systolic_feeder_pkg.sv | 29 ++
 rtl/systolic_feeder_operand_skew.sv | 56 +++++
 rtl/systolic_feeder.sv | 162 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic_feeder block.
//   MAT_DIM  : operand matrix dimension (2x2)
//   NUM_OPS  : operand bytes per job (A then B, row-major)
//   NUM_RES  : result bytes per job
//   DATA_W   : byte width of every data path
//   FEED_LEN : cycles needed to push skewed rows/columns into the array
//   state_t  : sequencer states
//   op_slot  : operand buffer slot of A[row][col] (is_b=0) or B[row][col] (is_b=1)
package systolic_feeder_pkg;

    localparam int MAT_DIM  = 2;
    localparam int NUM_OPS  = 8;
    localparam int NUM_RES  = 4;
    localparam int DATA_W   = 8;
    localparam int FEED_LEN = 2 * MAT_DIM - 1;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_EMIT
    } state_t;

    function automatic logic [2:0] op_slot(input logic is_b, input logic row, input logic col);
        return {is_b, row, col};
    endfunction

endpackage

// File: rtl/systolic_feeder_operand_skew.sv
// operand_skew: registered mux that places the skewed A rows and B columns onto
// the array inputs. Driven with the sequencer's next state/count so that the
// registered outputs line up with the FEED cycles themselves.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   st, t            : next sequencer state and FEED cycle index
//   ops              : 8-byte operand buffer (A00,A01,A10,A11,B00,B01,B10,B11)
//   arr_a0 / arr_a1  : row streams into the array
//   arr_b0 / arr_b1  : column streams into the array
module operand_skew
    import systolic_feeder_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  state_t                           st,
    input  logic [CNT_W-1:0]                 t,
    input  logic [NUM_OPS-1:0][DATA_W-1:0]   ops,
    output logic [DATA_W-1:0]                arr_a0,
    output logic [DATA_W-1:0]                arr_a1,
    output logic [DATA_W-1:0]                arr_b0,
    output logic [DATA_W-1:0]                arr_b1
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arr_a0 <= '0;
            arr_a1 <= '0;
            arr_b0 <= '0;
            arr_b1 <= '0;
        end else begin
            arr_a0 <= '0;
            arr_a1 <= '0;
            arr_b0 <= '0;
            arr_b1 <= '0;
            if (st == ST_FEED) begin
                // Row/column 1 lag row/column 0 by one cycle; every slot outside
                // the diagonal band stays zero.
                if (t == CNT_W'(0)) begin
                    arr_a0 <= ops[op_slot(1'b0, 1'b0, 1'b0)];
                    arr_b0 <= ops[op_slot(1'b1, 1'b0, 1'b0)];
                end else if (t == CNT_W'(1)) begin
                    arr_a0 <= ops[op_slot(1'b0, 1'b0, 1'b1)];
                    arr_a1 <= ops[op_slot(1'b0, 1'b1, 1'b0)];
                    arr_b0 <= ops[op_slot(1'b1, 1'b1, 1'b0)];
                    arr_b1 <= ops[op_slot(1'b1, 1'b0, 1'b1)];
                end else if (t == CNT_W'(2)) begin
                    arr_a1 <= ops[op_slot(1'b0, 1'b1, 1'b1)];
                    arr_b1 <= ops[op_slot(1'b1, 1'b1, 1'b1)];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: sequencer in front of the 2x2 systolic_array.
// Loads 8 operand bytes from the host, streams them skewed into the array,
// flushes with zeros, shifts the 4 results out of the array chain and re-emits
// them to the host over a valid/ready port.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready/in_data    : host operand byte stream (accepted in LOAD only)
//   arr_a0/arr_a1/arr_b0/arr_b1  : skewed operand streams to the array
//   chain_en / chain_out         : result chain control and data from the array
//   out_valid/out_ready/out_data : host result byte stream
//   busy                         : high whenever not in LOAD
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CHAIN_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] arr_a0,
    output logic [DATA_W-1:0] arr_a1,
    output logic [DATA_W-1:0] arr_b0,
    output logic [DATA_W-1:0] arr_b1,
    output logic              chain_en,
    input  logic [DATA_W-1:0] chain_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int DRAIN_LEN = CHAIN_LAT + NUM_RES;
    localparam int MAX_A     = (NUM_OPS > FLUSH_CYCLES) ? NUM_OPS : FLUSH_CYCLES;
    localparam int CNT_MAX   = (MAX_A > DRAIN_LEN) ? MAX_A : DRAIN_LEN;
    localparam int CNT_W     = $clog2(CNT_MAX);

    state_t                         st, st_n;
    logic [CNT_W-1:0]               cnt, cnt_n;
    logic [NUM_OPS-1:0][DATA_W-1:0] ops;
    logic [NUM_RES-1:0][DATA_W-1:0] res;
    logic [DATA_W-1:0]              out_sel;

    // Next-state/count logic. The single shared counter reaches its terminal
    // value only on the cycle that leaves the state, where it wraps to 0.
    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        case (st)
            ST_LOAD: begin
                if (in_valid && in_ready) begin
                    if (cnt == CNT_W'(NUM_OPS - 1)) begin
                        st_n  = ST_FEED;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            ST_FEED: begin
                if (cnt == CNT_W'(FEED_LEN - 1)) begin
                    st_n  = ST_FLUSH;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
                    st_n  = ST_DRAIN;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt == CNT_W'(DRAIN_LEN - 1)) begin
                    st_n  = ST_EMIT;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_EMIT: begin
                if (out_valid && out_ready) begin
                    if (cnt == CNT_W'(NUM_RES - 1)) begin
                        st_n  = ST_LOAD;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                st_n  = ST_LOAD;
                cnt_n = '0;
            end
        endcase
    end

    // Result byte for the next EMIT index.
    always_comb begin
        out_sel = '0;
        for (int unsigned k = 0; k < NUM_RES; k++) begin
            if (cnt_n == CNT_W'(k)) out_sel = res[k];
        end
    end

    // State and registered outputs; outputs are derived from the next state so
    // they are valid during the cycle the state is occupied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= ST_LOAD;
            cnt       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            chain_en  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            in_ready  <= (st_n == ST_LOAD);
            busy      <= (st_n != ST_LOAD);
            chain_en  <= (st_n == ST_DRAIN) && (cnt_n < CNT_W'(NUM_RES));
            out_valid <= (st_n == ST_EMIT);
            if (st_n == ST_EMIT) out_data <= out_sel;
        end
    end

    // Operand and result buffers carry no reset: they are only ever read after
    // being rewritten by the current job.
    always_ff @(posedge clk) begin
        if (rst_n && st == ST_LOAD && in_valid && in_ready) begin
            for (int unsigned k = 0; k < NUM_OPS; k++) begin
                if (cnt == CNT_W'(k)) ops[k] <= in_data;
            end
        end
        if (rst_n && st == ST_DRAIN) begin
            for (int unsigned k = 0; k < NUM_RES; k++) begin
                if (cnt == CNT_W'(CHAIN_LAT + k)) res[k] <= chain_out;
            end
        end
    end

    operand_skew #(
        .CNT_W (CNT_W)
    ) u_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .st     (st_n),
        .t      (cnt_n),
        .ops    (ops),
        .arr_a0 (arr_a0),
        .arr_a1 (arr_a1),
        .arr_b0 (arr_b0),
        .arr_b1 (arr_b1)
    );

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural 2x2 systolic array
// (output-stationary PEs, result chain pe00,pe01,pe10,pe11, one cycle latency).
module tb_systolic_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] arr_a0, arr_a1, arr_b0, arr_b1;
    logic       chain_en;
    logic [7:0] chain_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;

    logic [7:0] ops_tb [8];

    // behavioural array state
    logic [7:0] acc [4];
    logic [7:0] a_r00, b_r00, a_r10, b_r01, chain_q;

    always #5 clk = ~clk;

    systolic_feeder #(
        .FLUSH_CYCLES (2),
        .CHAIN_LAT    (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .arr_a0    (arr_a0),
        .arr_a1    (arr_a1),
        .arr_b0    (arr_b0),
        .arr_b1    (arr_b1),
        .chain_en  (chain_en),
        .chain_out (chain_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    assign chain_out = chain_q;

    always @(posedge clk) begin
        if (!busy) begin
            for (int i = 0; i < 4; i++) acc[i] <= 8'd0;
            a_r00 <= 8'd0; b_r00 <= 8'd0; a_r10 <= 8'd0; b_r01 <= 8'd0;
            chain_q <= 8'd0;
        end else if (chain_en) begin
            chain_q <= acc[0];
            acc[0]  <= acc[1];
            acc[1]  <= acc[2];
            acc[2]  <= acc[3];
            acc[3]  <= 8'd0;
        end else begin
            acc[0] <= acc[0] + 8'(arr_a0 * arr_b0);
            acc[1] <= acc[1] + 8'(a_r00 * arr_b1);
            acc[2] <= acc[2] + 8'(arr_a1 * b_r00);
            acc[3] <= acc[3] + 8'(a_r10 * b_r01);
            a_r00 <= arr_a0;
            b_r00 <= arr_b0;
            a_r10 <= arr_a1;
            b_r01 <= arr_b1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of FEED cycle 0.
    task automatic load_job(input bit random_gaps, input bit hold_after);
        int k = 0;
        int guard = 0;
        while (k < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid = random_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? ops_tb[k] : 8'hA5;
            if (in_valid && in_ready) k++;
        end
        check_eq("load_done", k, 8);
        @(negedge clk);
        in_valid = hold_after;
        in_data  = hold_after ? 8'hEE : 8'h00;
    endtask

    task automatic collect(input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input bit do_stall);
        logic [7:0] exp_b [4];
        logic [7:0] held;
        int en_cnt = 0;
        int got = 0;
        int cyc = 0;
        bit stall = do_stall;
        exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
        out_ready = 1'b1;
        while (got < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (chain_en) en_cnt++;
            if (out_valid) begin
                if (stall && got == 1) begin
                    out_ready = 1'b0;
                    held = out_data;
                    repeat (5) begin
                        @(negedge clk);
                        cyc++;
                        check_eq("stall_valid", 32'(out_valid), 32'd1);
                        check_eq("stall_data", 32'(out_data), 32'(held));
                    end
                    out_ready = 1'b1;
                    stall = 1'b0;
                end
                check_eq($sformatf("res%0d", got), 32'(out_data), 32'(exp_b[got]));
                got++;
            end
        end
        check_eq("emit_count", got, 4);
        check_eq("chain_en_cycles", en_cnt, 4);
        @(negedge clk);
        check_eq("post_out_valid", 32'(out_valid), 32'd0);
        check_eq("post_in_ready", 32'(in_ready), 32'd1);
        check_eq("post_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_chain_en"}, 32'(chain_en), 32'd0);
        check_eq({tag, "_out_data"}, 32'(out_data), 32'd0);
        check_eq({tag, "_arr"}, {arr_a0, arr_a1, arr_b0, arr_b1}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset");

        // Job 1: skew pattern, full result, EMIT stall
        ops_tb = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        acc_cnt = 0;
        load_job(1'b0, 1'b0);
        check_eq("feed_t0", {arr_a0, arr_a1, arr_b0, arr_b1}, 32'h01_00_05_00);
        check_eq("feed_busy", 32'(busy), 32'd1);
        check_eq("feed_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("feed_t1", {arr_a0, arr_a1, arr_b0, arr_b1}, 32'h02_03_07_06);
        @(negedge clk);
        check_eq("feed_t2", {arr_a0, arr_a1, arr_b0, arr_b1}, 32'h00_04_00_08);
        repeat (2) begin
            @(negedge clk);
            check_eq("flush_arr", {arr_a0, arr_a1, arr_b0, arr_b1}, 32'd0);
            check_eq("flush_chain_en", 32'(chain_en), 32'd0);
        end
        collect(8'd19, 8'd22, 8'd43, 8'd50, 1'b1);
        check_eq("job1_accepts", acc_cnt, 8);

        // Job 2: gappy load, in_valid held high after load
        acc_cnt = 0;
        load_job(1'b1, 1'b1);
        collect(8'd19, 8'd22, 8'd43, 8'd50, 1'b0);
        in_valid = 1'b0;
        check_eq("job2_accepts", acc_cnt, 8);

        // Job 3: reset mid-FEED, then A=I, B=[[9,8],[7,6]]
        load_job(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("midreset");
        ops_tb = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6};
        acc_cnt = 0;
        load_job(1'b0, 1'b0);
        collect(8'd9, 8'd8, 8'd7, 8'd6, 1'b0);
        check_eq("job3_accepts", acc_cnt, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
